mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-stage responder to the execute stage of the MIPS pipeline.
- Accepts the execute result (address/ALU value, store data, access size, load/store intent) and drives a req/ack data-memory port.
- Performs big-endian byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Delivers one registered writeback record per accepted operation.

Parameters:
- ADDR_WIDTH, 32, data-memory address width.
- TIMEOUT_CYCLES, 255, maximum cycles dm_req may stay high without dm_ack before abort.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  execute result valid this cycle
- ex_ready  output  1  stage can accept; high only in IDLE
- ex_addr  input  32  ALU result: memory address, or writeback value on bypass
- ex_store_data  input  32  rt value for stores
- ex_rw_d  input  1  1 = memory operation, 0 = ALU bypass
- ex_store  input  1  1 = store, 0 = load; ignored when ex_rw_d=0
- ex_access_size  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- ex_unsigned  input  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend
- ex_rd  input  5  destination register
- dm_req  output  1  memory request, held until dm_ack
- dm_addr  output  ADDR_WIDTH  request address
- dm_we  output  1  1 = write
- dm_byte_en  output  4  lane enables, bit3 = bits 31:24
- dm_wdata  output  32  lane-steered store data
- dm_ack  input  1  request complete; rdata valid same cycle
- dm_rdata  input  32  read data
- wb_valid  output  1  one-cycle writeback pulse
- wb_we  output  1  register-file write enable for this record
- wb_rd  output  5  destination register
- wb_data  output  32  writeback value
- mem_err  output  1  one-cycle pulse on timeout (or misalignment, see feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; ex_ready 1 in the cycle after reset deasserts.
- Reset mid-ACCESS: dm_req drops at the next edge. No writeback is produced and no error is raised.
- States:
  - IDLE: ex_ready=1.
    - ex_valid and ex_rw_d=0: register wb_data=ex_addr, wb_rd=ex_rd, wb_we=(ex_rd!=0); go RESP.
    - ex_valid and ex_rw_d=1: latch all request fields; go ACCESS.
  - ACCESS: dm_req=1 with dm_addr/dm_we/dm_byte_en/dm_wdata stable every cycle.
    - On dm_ack: latch the formatted load data; go RESP.
    - If dm_ack has not arrived when the timeout counter reaches TIMEOUT_CYCLES: drop dm_req, pulse mem_err, set wb_we=0; go RESP.
  - RESP: wb_valid=1 for exactly one cycle; go IDLE. ex_ready=0.
- Latency:
  - Bypass accepted at edge N: wb_valid is high in cycle N+1.
  - Memory accepted at edge N: dm_req is high from cycle N+1; dm_ack sampled at edge K gives wb_valid in cycle K+1.
  - Minimum memory latency is 3 cycles. Back-to-back throughput is one operation per 2 cycles (bypass) or per 3 or more cycles (memory).
- dm_ack outside ACCESS is ignored.
- The timeout counter clears on entry to ACCESS.
- Stores:
  - Byte: wdata = {4{b}}, byte_en = 4'b1000 >> addr[1:0].
  - Half: wdata = {2{h}}, byte_en = addr[1] ? 0011 : 1100.
  - Word: byte_en = 1111.
  - Stores retire with wb_valid=1, wb_we=0.
- Loads: dm_we=0 and byte_en=1111 always.
  - Byte lane select: addr[1:0]=00 selects bits 31:24, 11 selects bits 7:0.
  - Half lane select: addr[1]=0 selects bits 31:16.
  - Extension follows ex_unsigned.
  - wb_we = (ex_rd != 0).
- dm_addr = ex_addr word-aligned (low 2 bits forced 0).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is not issued. The block goes IDLE->RESP directly, with mem_err pulsed together with wb_valid and wb_we=0.
- Undefined: low address bits are ignored for alignment; half uses addr[1] and word uses the full aligned word, with no error.

Test Plan:
- Bypass: ex_addr=0x0000_1234, ex_rd=5 -> wb_valid next cycle, wb_data=0x1234, wb_we=1; dm_req never asserted.
- SB: addr=0x103, data=0xAB -> dm_byte_en=0001, dm_wdata=0xABABABAB, dm_we=1; ack after 4 cycles -> wb_valid with wb_we=0.
- LB vs LBU: addr=0x101, dm_rdata=0x11F0_2233 -> LB gives wb_data=0xFFFF_FFF0, LBU gives 0x0000_00F0.
- LW with dm_req held 3 cycles: verify dm_addr/dm_wdata stable, ex_ready=0 throughout, wb_data=dm_rdata.
- Timeout (TIMEOUT_CYCLES=8), no ack: dm_req drops after 8 cycles, mem_err pulses, wb_valid with wb_we=0. Reset asserted mid-ACCESS: dm_req=0 next cycle, no wb_valid.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> no dm_req, mem_err=1, wb_we=0. Without it: dm_addr=0x100, normal load.

Source files
------------

// File: rtl/mem_access_stage.sv
// MIPS memory stage: accepts execute results, drives a req/ack data-memory port with big-endian lane steering,
// and emits one writeback record per operation. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [31:0]           ex_addr,
  input  logic [31:0]           ex_store_data,
  input  logic                  ex_rw_d,
  input  logic                  ex_store,
  input  logic [1:0]            ex_access_size,
  input  logic                  ex_unsigned,
  input  logic [4:0]            ex_rd,
  output logic                  dm_req,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic                  dm_we,
  output logic [3:0]            dm_byte_en,
  output logic [31:0]           dm_wdata,
  input  logic                  dm_ack,
  input  logic [31:0]           dm_rdata,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  mem_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            lo;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic                  we;
    logic [1:0]            size;
    logic                  uns;
    logic [4:0]            rd;
  } req_t;

  state_t          state, state_d;
  req_t            rq;
  logic [TW-1:0]   tcnt;
  logic            misal;
  logic [31:0]     st_wdata;
  logic [3:0]      st_be;
  logic [31:0]     ld_data;
  logic [3:0][7:0] rlanes;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;

`ifdef MEM_MISALIGN_TRAP_EN
  // Size 11 is handled as a word, so it traps on the same rule.
  assign misal = ex_rw_d &&
                 ((ex_access_size == 2'b01 && ex_addr[0]) ||
                  ((ex_access_size == 2'b00 || ex_access_size == 2'b11) && ex_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    st_wdata = ex_store_data;
    st_be    = 4'b1111;
    case (ex_access_size)
      2'b10: begin
        st_wdata = {4{ex_store_data[7:0]}};
        st_be    = 4'b1000 >> ex_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{ex_store_data[15:0]}};
        st_be    = ex_addr[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  // Big-endian: lane 3 (bits 31:24) is byte offset 0, so the lane index is ~lo.
  assign rlanes = dm_rdata;
  assign ld_b   = rlanes[~rq.lo];
  assign ld_h   = rq.lo[1] ? dm_rdata[15:0] : dm_rdata[31:16];

  always_comb begin
    ld_data = dm_rdata;
    case (rq.size)
      2'b10:   ld_data = rq.uns ? {24'b0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld_data = rq.uns ? {16'b0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (ex_valid) state_d = (!ex_rw_d || misal) ? RESP : ACCESS;
      ACCESS:  if (dm_ack || tcnt == TMAX) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rq      <= '0;
      tcnt    <= '0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          wb_rd <= ex_rd;
          if (!ex_rw_d) begin
            wb_data <= ex_addr;
            wb_we   <= (ex_rd != 5'd0);
          end else if (misal) begin
            wb_data <= '0;
            wb_we   <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            rq.addr  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
            rq.lo    <= ex_addr[1:0];
            rq.we    <= ex_store;
            rq.wdata <= ex_store ? st_wdata : 32'd0;
            rq.be    <= ex_store ? st_be : 4'b1111;
            rq.size  <= ex_access_size;
            rq.uns   <= ex_unsigned;
            rq.rd    <= ex_rd;
            tcnt     <= '0;
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            wb_data <= rq.we ? 32'd0 : ld_data;
            wb_we   <= !rq.we && (rq.rd != 5'd0);
          end else if (tcnt == TMAX) begin
            wb_data <= '0;
            wb_we   <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_ready   = (state == IDLE) && !reset;
  assign dm_req     = (state == ACCESS);
  assign wb_valid   = (state == RESP);
  assign dm_addr    = rq.addr;
  assign dm_we      = rq.we;
  assign dm_byte_en = rq.be;
  assign dm_wdata   = rq.wdata;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expected writeback records, a negedge monitor pops and compares.
module tb_mem_access_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_addr, ex_store_data;
  logic        ex_rw_d, ex_store, ex_unsigned;
  logic [1:0]  ex_access_size;
  logic [4:0]  ex_rd;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byte_en;
  logic        wb_valid, wb_we, mem_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_access_stage #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_addr(ex_addr), .ex_store_data(ex_store_data), .ex_rw_d(ex_rw_d), .ex_store(ex_store),
    .ex_access_size(ex_access_size), .ex_unsigned(ex_unsigned), .ex_rd(ex_rd),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_byte_en(dm_byte_en),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                      input logic err, input logic chk_data);
    exp_t x;
    x.we = we; x.rd = rd; x.data = data; x.err = err; x.chk_data = chk_data;
    sbq.push_back(x);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (wb_valid) begin
        if (sbq.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          if (e.chk_data) chk("wb_data", wb_data, e.data);
          chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        end
      end else if (mem_err) chk("mem_err_stray", 32'd1, 32'd0);
    end
  end

  task automatic issue(input logic rw, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    int n = 0;
    while (!ex_ready && n < 20) begin @(posedge clock); #1; n++; end
    if (!ex_ready) chk("ex_ready_wait", 32'd0, 32'd1);
    ex_valid = 1'b1; ex_rw_d = rw; ex_store = st; ex_access_size = sz; ex_unsigned = uns;
    ex_addr = a; ex_store_data = d; ex_rd = rd;
    @(posedge clock); #1;
    ex_valid = 1'b0;
  endtask

  // Called right after issue(): dm_req is expected high now; ack arrives in the n-th request cycle.
  task automatic serve(input int n, input logic [31:0] rdata, input logic [31:0] ea, input logic ewe,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic chk_wd);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clock); #1; end
      chk("dm_req", {31'd0, dm_req}, 32'd1);
      chk("dm_addr", dm_addr, ea);
      chk("dm_we", {31'd0, dm_we}, {31'd0, ewe});
      chk("dm_byte_en", {28'd0, dm_byte_en}, {28'd0, ebe});
      if (chk_wd) chk("dm_wdata", dm_wdata, ewd);
      chk("ex_ready_busy", {31'd0, ex_ready}, 32'd0);
    end
    dm_ack = 1'b1; dm_rdata = rdata;
    @(posedge clock); #1;
    dm_ack = 1'b0; dm_rdata = '0;
    chk("wb_valid_after_ack", {31'd0, wb_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1; ex_valid = 0; ex_addr = 0; ex_store_data = 0; ex_rw_d = 0; ex_store = 0;
    ex_access_size = 0; ex_unsigned = 0; ex_rd = 0; dm_ack = 0; dm_rdata = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_outputs", {dm_req, dm_we, dm_byte_en, wb_valid, wb_we, mem_err, ex_ready}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("ready_after_rst", {31'd0, ex_ready}, 32'd1);

    // Bypass, then a second back-to-back bypass to r0 (no register write)
    push(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
    chk("byp_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("byp_no_req", {31'd0, dm_req}, 32'd0);
    push(1'b0, 5'd0, 32'hCAFE_0001, 1'b0, 1'b1);
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'hCAFE_0001, 32'h0, 5'd0);
    chk("byp2_no_req", {31'd0, dm_req}, 32'd0);

    // SB at 0x103
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0103, 32'h0000_00AB, 5'd0);
    serve(4, 32'h0, 32'h0000_0100, 1'b1, 4'b0001, 32'hABAB_ABAB, 1'b1);

    // SH at 0x102, SW at 0x104
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 5'd0);
    serve(1, 32'h0, 32'h0000_0100, 1'b1, 4'b0011, 32'hABCD_ABCD, 1'b1);
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 5'd0);
    serve(2, 32'h0, 32'h0000_0104, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b1);

    // LB / LBU at 0x101
    push(1'b1, 5'd7, 32'hFFFF_FFF0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd7);
    serve(1, 32'h11F0_2233, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);
    push(1'b1, 5'd7, 32'h0000_00F0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0, 5'd7);
    serve(1, 32'h11F0_2233, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);
    // LB at lanes 0 and 3
    push(1'b1, 5'd8, 32'h0000_0011, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd8);
    serve(1, 32'h11F0_2233, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);
    push(1'b1, 5'd8, 32'h0000_0033, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0103, 32'h0, 5'd8);
    serve(1, 32'h11F0_2233, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);

    // LH / LHU at 0x102 (low half), LH at 0x100 (high half)
    push(1'b1, 5'd10, 32'hFFFF_8234, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 5'd10);
    serve(1, 32'h11F0_8234, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);
    push(1'b1, 5'd10, 32'h0000_8234, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 5'd10);
    serve(1, 32'h11F0_8234, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);
    push(1'b1, 5'd11, 32'h0000_11F0, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0, 5'd11);
    serve(1, 32'h11F0_8234, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);

    // LW held 3 cycles; LW to r0 does not write
    push(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0, 5'd9);
    serve(3, 32'hDEAD_BEEF, 32'h0000_0200, 1'b0, 4'b1111, dm_wdata, 1'b0);
    push(1'b0, 5'd0, 32'h0123_4567, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0, 5'd0);
    serve(1, 32'h0123_4567, 32'h0000_0300, 1'b0, 4'b1111, 32'h0, 1'b0);

    // Misaligned LW at 0x102
`ifdef MEM_MISALIGN_TRAP_EN
    push(1'b0, 5'd3, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 5'd3);
    chk("mis_no_req", {31'd0, dm_req}, 32'd0);
    chk("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("mis_err", {31'd0, mem_err}, 32'd1);
`else
    push(1'b1, 5'd3, 32'h5566_7788, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 5'd3);
    serve(1, 32'h5566_7788, 32'h0000_0100, 1'b0, 4'b1111, 32'h0, 1'b0);
`endif

    // dm_ack while idle is ignored
    @(posedge clock); #1;
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    dm_ack = 1'b0; dm_rdata = '0;
    chk("stray_ack_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("stray_ack_ready", {31'd0, ex_ready}, 32'd1);

    // Timeout: no ack, request must stay up exactly 8 cycles
    push(1'b0, 5'd12, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0400, 32'h0, 5'd12);
    cnt = 0;
    while (dm_req && cnt < 50) begin cnt++; @(posedge clock); #1; end
    chk("timeout_req_cycles", cnt, 32'd8);
    chk("timeout_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("timeout_err", {31'd0, mem_err}, 32'd1);

    // Reset mid-ACCESS
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0500, 32'h0, 5'd13);
    @(posedge clock); #1;
    chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_req", {31'd0, dm_req}, 32'd0);
    chk("rst_mid_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_mid_err", {31'd0, mem_err}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_mid_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_mid_no_wb", {31'd0, wb_valid}, 32'd0);
    repeat (3) @(posedge clock);
    #1;

    chk("sb_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
